// File: rtl/arc4_pkg.sv
// Shared types and constants for the ARC4 sequencer.
//   phase_t       : externally visible phase (which engine owns S, or idle/done/error)
//   sched_state_t : internal sequencer state (start/wait split per engine)
//   state_phase() : maps an internal state onto the phase it reports
package arc4_pkg;

    localparam int S_ADDR_W = 8;
    localparam int S_DATA_W = 8;
    localparam int S_DEPTH  = 256;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_INIT = 3'd1,
        PH_KSA  = 3'd2,
        PH_PRGA = 3'd3,
        PH_DONE = 3'd4,
        PH_ERR  = 3'd5
    } phase_t;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_INIT = 4'd1,
        WT_INIT = 4'd2,
        ST_KSA  = 4'd3,
        WT_KSA  = 4'd4,
        ST_PRGA = 4'd5,
        WT_PRGA = 4'd6,
        ST_DONE = 4'd7,
        ST_ERR  = 4'd8
    } sched_state_t;

    function automatic phase_t state_phase(input sched_state_t s);
        phase_t p;
        case (s)
            ST_INIT, WT_INIT: p = PH_INIT;
            ST_KSA,  WT_KSA:  p = PH_KSA;
            ST_PRGA, WT_PRGA: p = PH_PRGA;
            ST_DONE:          p = PH_DONE;
            ST_ERR:           p = PH_ERR;
            default:          p = PH_IDLE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/arc4_sched_s_port_mux.sv
// Combinational 3:1 mux onto the single S-memory port.
//   owner                       : current phase; only INIT/KSA/PRGA own the port
//   {init,ksa,prga}_{addr,wrdata,wren} : engine-side port requests
//   s_addr/s_wrdata/s_wren      : shared port; all zero when no engine owns it
module s_port_mux
    import arc4_pkg::*;
(
    input  phase_t              owner,
    input  logic [S_ADDR_W-1:0] init_addr,
    input  logic [S_DATA_W-1:0] init_wrdata,
    input  logic                init_wren,
    input  logic [S_ADDR_W-1:0] ksa_addr,
    input  logic [S_DATA_W-1:0] ksa_wrdata,
    input  logic                ksa_wren,
    input  logic [S_ADDR_W-1:0] prga_addr,
    input  logic [S_DATA_W-1:0] prga_wrdata,
    input  logic                prga_wren,
    output logic [S_ADDR_W-1:0] s_addr,
    output logic [S_DATA_W-1:0] s_wrdata,
    output logic                s_wren
);

    always_comb begin
        s_addr   = '0;
        s_wrdata = '0;
        s_wren   = 1'b0;
        case (owner)
            PH_INIT: begin
                s_addr   = init_addr;
                s_wrdata = init_wrdata;
                s_wren   = init_wren;
            end
            PH_KSA: begin
                s_addr   = ksa_addr;
                s_wrdata = ksa_wrdata;
                s_wren   = ksa_wren;
            end
            PH_PRGA: begin
                s_addr   = prga_addr;
                s_wrdata = prga_wrdata;
                s_wren   = prga_wren;
            end
            default: ; // no owner: port parked at zero, no write can leak through
        endcase
    end

endmodule

// File: rtl/arc4_sched.sv
// ARC4 sequencer and S-memory arbiter: runs init -> ksa -> prga using en/rdy
// handshakes and hands the single S port to whichever engine is active.
//   clk, rst                : clock, synchronous active-high reset
//   en / rdy                : start request / idle-accepting (IDLE, DONE, ERR)
//   err                     : a phase timed out; sticky until next accepted en
//   phase                   : phase_t view of the sequencer
//   {init,ksa,prga}_en      : one-cycle engine start pulses
//   {init,ksa,prga}_rdy     : engine ready
//   {init,ksa,prga}_{addr,wrdata,wren} : engine S-port requests
//   s_addr/s_wrdata/s_wren  : shared S-memory port
module arc4_sched
    import arc4_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    output logic                rdy,
    output logic                err,
    output phase_t              phase,
    output logic                init_en,
    output logic                ksa_en,
    output logic                prga_en,
    input  logic                init_rdy,
    input  logic                ksa_rdy,
    input  logic                prga_rdy,
    input  logic [S_ADDR_W-1:0] init_addr,
    input  logic [S_DATA_W-1:0] init_wrdata,
    input  logic                init_wren,
    input  logic [S_ADDR_W-1:0] ksa_addr,
    input  logic [S_DATA_W-1:0] ksa_wrdata,
    input  logic                ksa_wren,
    input  logic [S_ADDR_W-1:0] prga_addr,
    input  logic [S_DATA_W-1:0] prga_wrdata,
    input  logic                prga_wren,
    output logic [S_ADDR_W-1:0] s_addr,
    output logic [S_DATA_W-1:0] s_wrdata,
    output logic                s_wren
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO = CNT_W'(2);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    sched_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Engine status and successor state for the phase currently waiting.
    logic             wt_rdy;
    sched_state_t     wt_next;
    logic [CNT_W-1:0] cnt_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        wt_rdy  = 1'b0;
        wt_next = ST_IDLE;
        case (state_q)
            WT_INIT: begin wt_rdy = init_rdy; wt_next = ST_KSA;  end
            WT_KSA:  begin wt_rdy = ksa_rdy;  wt_next = ST_PRGA; end
            WT_PRGA: begin wt_rdy = prga_rdy; wt_next = ST_DONE; end
            default: ;
        endcase
    end

    // Saturating: the counter can never wrap back below TIMEOUT.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // The counter restarts at the engine pulse and includes the pulse cycle,
    // so cnt_q is the number of cycles elapsed since the pulse. That lets
    // cnt_q==1 identify the cycle right after the pulse, whose rdy is stale.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        init_en = 1'b0;
        ksa_en  = 1'b0;
        prga_en = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (en) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            ST_INIT: begin
                if (init_rdy) begin
                    init_en = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = WT_INIT;
                end
            end
            ST_KSA: begin
                if (ksa_rdy) begin
                    ksa_en  = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = WT_KSA;
                end
            end
            ST_PRGA: begin
                if (prga_rdy) begin
                    prga_en = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = WT_PRGA;
                end
            end
            WT_INIT, WT_KSA, WT_PRGA: begin
                // Completion is tested first so it wins over a simultaneous timeout.
                if (wt_rdy && (cnt_q >= CNT_TWO)) begin
                    state_d = wt_next;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_MAX) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign phase = state_phase(state_q);
    assign rdy   = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR);
    assign err   = err_q;

    s_port_mux u_s_port_mux (
        .owner       (phase),
        .init_addr   (init_addr),
        .init_wrdata (init_wrdata),
        .init_wren   (init_wren),
        .ksa_addr    (ksa_addr),
        .ksa_wrdata  (ksa_wrdata),
        .ksa_wren    (ksa_wren),
        .prga_addr   (prga_addr),
        .prga_wrdata (prga_wrdata),
        .prga_wren   (prga_wren),
        .s_addr      (s_addr),
        .s_wrdata    (s_wrdata),
        .s_wren      (s_wren)
    );

endmodule

// File: tb/tb_arc4_sched.sv
// Scoreboard bench for arc4_sched: stub engines with programmable latency,
// a behavioural S memory, and a timing model that predicts every engine
// pulse and the DONE/ERR entry cycle from the handshake rules.
module tb_arc4_sched;
    import arc4_pkg::*;

    localparam int TO = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       rdy, err;
    phase_t     phase;
    logic       init_en, ksa_en, prga_en;
    logic       init_rdy, ksa_rdy, prga_rdy;
    logic [7:0] init_addr, init_wrdata, ksa_addr, ksa_wrdata, prga_addr, prga_wrdata;
    logic       init_wren, ksa_wren, prga_wren;
    logic [7:0] s_addr, s_wrdata;
    logic       s_wren;

    arc4_sched #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .en(en), .rdy(rdy), .err(err), .phase(phase),
        .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
        .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
        .init_addr(init_addr), .init_wrdata(init_wrdata), .init_wren(init_wren),
        .ksa_addr(ksa_addr), .ksa_wrdata(ksa_wrdata), .ksa_wren(ksa_wren),
        .prga_addr(prga_addr), .prga_wrdata(prga_wrdata), .prga_wren(prga_wren),
        .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- stub engines ----------------
    int   lat [3];
    int   cnt [3];
    logic rdy_r [3];
    int   init_ready_at = 0;
    bit   init_wr_mode  = 1'b0;
    bit   iso_mode      = 1'b0;
    logic [2:0] en_v;
    assign en_v = {prga_en, ksa_en, init_en};

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                rdy_r[i] <= 1'b1;
                cnt[i]   <= 0;
            end else if (en_v[i]) begin
                if (lat[i] > 0) begin
                    rdy_r[i] <= 1'b0;
                    cnt[i]   <= lat[i];
                end
            end else if (cnt[i] > 0) begin
                cnt[i] <= cnt[i] - 1;
                if (cnt[i] == 1) rdy_r[i] <= 1'b1;
            end
        end
    end

    assign init_rdy    = rdy_r[0] && (cyc >= init_ready_at);
    assign ksa_rdy     = rdy_r[1];
    assign prga_rdy    = rdy_r[2];
    assign init_wren   = init_wr_mode && (cnt[0] > 0);
    assign init_addr   = 8'(256 - cnt[0]);
    assign init_wrdata = 8'(256 - cnt[0]);
    // Intruders: write requests from non-owners while init is busy.
    assign ksa_wren    = iso_mode && (cnt[0] > 0);
    assign ksa_addr    = 8'hAA;
    assign ksa_wrdata  = 8'h55;
    assign prga_wren   = iso_mode && (cnt[0] > 0);
    assign prga_addr   = 8'h33;
    assign prga_wrdata = 8'h77;

    // ---------------- S memory ----------------
    logic [7:0] mem [256];
    bit mem_clear = 1'b0;
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'hFF;
        end else if (s_wren) begin
            mem[s_addr] <= s_wrdata;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int code;   // 1 init_en, 2 ksa_en, 3 prga_en, 4 enter DONE, 5 enter ERR
        int at;
    } ev_t;
    ev_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_ev(input int code);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: got code %0d at cycle %0d, expected none", code, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.code != code || e.at != cyc) begin
                n_fail++;
                $display("FAIL event: got code %0d at cycle %0d, expected code %0d at cycle %0d",
                         code, cyc, e.code, e.at);
            end else begin
                $display("[TB] event code %0d at cycle %0d ok", code, cyc);
            end
        end
    endtask

    bit     mon_on    = 1'b0;
    bit     quiet_en  = 1'b0;
    int     quiet_from = 0;
    phase_t prev_ph   = PH_IDLE;

    always @(negedge clk) begin
        logic [7:0] ea, ed;
        logic       ew;
        if (mon_on) begin
            if (init_en) check_ev(1);
            if (ksa_en)  check_ev(2);
            if (prga_en) check_ev(3);
            if (phase == PH_DONE && prev_ph != PH_DONE) begin
                check_ev(4);
                chk("done_rdy", 32'(rdy), 32'd1);
                chk("done_err", 32'(err), 32'd0);
            end
            if (phase == PH_ERR && prev_ph != PH_ERR) begin
                check_ev(5);
                chk("err_flag", 32'(err), 32'd1);
                chk("err_rdy", 32'(rdy), 32'd1);
            end
            // Port must carry exactly the owning engine's request, zero otherwise.
            ea = 8'h00; ed = 8'h00; ew = 1'b0;
            case (phase)
                PH_INIT: begin ea = init_addr; ed = init_wrdata; ew = init_wren; end
                PH_KSA:  begin ea = ksa_addr;  ed = ksa_wrdata;  ew = ksa_wren;  end
                PH_PRGA: begin ea = prga_addr; ed = prga_wrdata; ew = prga_wren; end
                default: ;
            endcase
            n_tests++;
            if (s_addr !== ea || s_wrdata !== ed || s_wren !== ew) begin
                n_fail++;
                $display("FAIL port: got addr %0h data %0h wren %0b, expected %0h %0h %0b (cycle %0d)",
                         s_addr, s_wrdata, s_wren, ea, ed, ew, cyc);
            end
            if (quiet_en && cyc >= quiet_from && cyc < quiet_from + 3)
                chk("post_init_wren", 32'(s_wren), 32'd0);
            prev_ph = phase;
        end
    end

    // ---------------- reference timing model ----------------
    // An engine pulsed at p with latency L has rdy low for L cycles and is
    // noticed at p+max(L+1,2); the next phase pulses the cycle after. If that
    // is later than p+TO-1 the sequencer enters ERR at p+TO instead.
    task automatic model_run(input int c0, input int d_init, output int fe, output bit fe_err);
        int p;
        int cc;
        p = c0 + 1 + d_init;
        fe_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(ev_t'{code: i + 1, at: p});
            cc = p + ((lat[i] + 1 > 2) ? lat[i] + 1 : 2);
            if (cc > p + TO - 1) begin
                exp_q.push_back(ev_t'{code: 5, at: p + TO});
                fe = p + TO;
                fe_err = 1'b1;
                return;
            end
            if (i == 0) quiet_from = cc + 1;
            p = cc + 1;
        end
        exp_q.push_back(ev_t'{code: 4, at: p});
        fe = p;
    endtask

    task automatic wait_idle();
        int k = 0;
        while (!(rdy && rdy_r[0] && rdy_r[1] && rdy_r[2]) && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 2000) begin
            n_tests++; n_fail++;
            $display("FAIL idle_wait: sequencer/stubs not ready after %0d cycles", k);
        end
    endtask

    task automatic start_run(input int d_init, output int c0, output int fe, output bit fe_err);
        wait_idle();
        @(posedge clk); #1;
        c0 = cyc;
        init_ready_at = c0 + 1 + d_init;
        en = 1'b1;
        model_run(c0, d_init, fe, fe_err);
        @(posedge clk); #1;
        en = 1'b0;
        chk("err_cleared", 32'(err), 32'd0);
        chk("busy_rdy", 32'(rdy), 32'd0);
    endtask

    task automatic run_one(input int d_init, input bit spurious, input string tag);
        int c0, fe, budget;
        bit fe_err;
        start_run(d_init, c0, fe, fe_err);
        budget = fe - cyc + 50;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk); #1;
            en = (spurious && cyc < fe && $urandom_range(0, 5) == 0);
            budget--;
        end
        en = 1'b0;
        if (exp_q.size() > 0) begin
            n_tests++; n_fail++;
            $display("FAIL %s: %0d expected events never seen", tag, exp_q.size());
            exp_q.delete();
        end
        chk("end_rdy", 32'(rdy), 32'd1);
        chk("end_err", 32'(err), 32'(fe_err));
        chk("end_phase", 32'(phase), fe_err ? 32'(PH_ERR) : 32'(PH_DONE));
        $display("[TB] run %s: lat %0d/%0d/%0d init_delay %0d -> %s at cycle %0d",
                 tag, lat[0], lat[1], lat[2], d_init, fe_err ? "ERR" : "DONE", fe);
    endtask

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 9));
        case (r)
            0: return 0;
            1: return 1;
            2: return TO - 2;
            3: return TO - 1;
            default: return int'($urandom_range(2, 30));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, fe;
        bit fe_err;
        lat[0] = 10; lat[1] = 10; lat[2] = 10;

        // Reset state.
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_phase", 32'(phase), 32'(PH_IDLE));
        chk("rst_en", 32'({init_en, ksa_en, prga_en}), 32'd0);
        chk("rst_port", 32'({s_addr, s_wrdata, s_wren}), 32'd0);
        prev_ph = phase;
        mon_on = 1'b1;

        // Basic sequence with 10-cycle stubs.
        run_one(0, 1'b0, "basic");

        // Real init writes, intruding ksa/prga requests during INIT.
        @(posedge clk); #1 mem_clear = 1'b1;
        @(posedge clk); #1 mem_clear = 1'b0;
        lat[0] = 256; lat[1] = 0; lat[2] = 0;
        init_wr_mode = 1'b1; iso_mode = 1'b1; quiet_en = 1'b1;
        run_one(0, 1'b0, "mem_init");
        init_wr_mode = 1'b0; iso_mode = 1'b0; quiet_en = 1'b0;
        for (int i = 0; i < 256; i++) chk("mem", 32'(mem[i]), 32'(i));
        chk("mem_aa", 32'(mem[8'hAA]), 32'hAA);

        // Timeout in KSA, then recovery; prga must never pulse.
        lat[0] = 3; lat[1] = TO + 20; lat[2] = 3;
        run_one(0, 1'b0, "ksa_timeout");
        lat[1] = 5;
        run_one(0, 1'b0, "after_err");

        // Boundary: completion on the last allowed cycle vs one cycle late.
        lat[0] = 2; lat[1] = TO - 2; lat[2] = 2;
        run_one(0, 1'b0, "edge_complete");
        lat[1] = TO - 1;
        run_one(0, 1'b0, "edge_timeout");

        // Init not ready at start, with spurious en pulses while busy.
        lat[0] = 4; lat[1] = 6; lat[2] = 8;
        run_one(4, 1'b1, "init_late");

        // Reset in the middle of WT_KSA.
        lat[0] = 5; lat[1] = 100; lat[2] = 5;
        start_run(0, c0, fe, fe_err);
        repeat (28) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        chk("midrst_en", 32'({init_en, ksa_en, prga_en}), 32'd0);
        chk("midrst_wren", 32'(s_wren), 32'd0);
        chk("midrst_rdy", 32'(rdy), 32'd1);
        chk("midrst_phase", 32'(phase), 32'(PH_IDLE));
        $display("[TB] run mid_reset: reset applied at cycle %0d", cyc - 1);
        lat[1] = 7;
        run_one(0, 1'b0, "after_reset");

        // Randomized runs.
        for (int r = 0; r < 10; r++) begin
            lat[0] = pick_lat(); lat[1] = pick_lat(); lat[2] = pick_lat();
            run_one(int'($urandom_range(0, 5)), 1'b1, $sformatf("rand%0d", r));
        end

        repeat (5) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
